// File: rtl/blink_pkg.sv
// Shared widths, limits and debouncer state encoding for the blink-rate controller.
package blink_pkg;

  localparam int RATE_W = 3;
  localparam int HP_W   = 27;
  localparam logic [RATE_W-1:0] MAX_RATE = 3'd7;

  typedef enum logic [1:0] {
    IDLE,
    ARMING,
    HELD,
    RELEASING
  } dbState_e;

  // Each rate step halves the blink period; the result is a terminal count, hence the -1.
  function automatic logic [HP_W-1:0] calcHalfPeriod(input int base, input logic [RATE_W-1:0] idx);
    logic [HP_W-1:0] baseW;
    baseW = HP_W'(base);
    return (baseW >> idx) - HP_W'(1);
  endfunction

endpackage

// File: rtl/blink_rate_ctrl_debouncer.sv
// Two-flop synchronizer plus four-state debouncer emitting a single press strobe per accepted press.
module button_debouncer
  import blink_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 2000000
) (
  input  logic clock,
  input  logic reset,
  input  logic enable_i,
  input  logic btn_i,
  output logic strobe_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [1:0]       syncQ;
  dbState_e         stateQ, stateD;
  logic [CNT_W-1:0] cntQ, cntD;
  logic             btnSync;
  logic [CNT_W-1:0] cntInc;

  assign btnSync = syncQ[1];
  assign cntInc  = (cntQ == CNT_MAX) ? cntQ : cntQ + CNT_W'(1);

  always_ff @(posedge clock) begin
    if (reset) begin
      syncQ  <= '0;
      stateQ <= IDLE;
      cntQ   <= '0;
    end else begin
      syncQ  <= {syncQ[0], btn_i};
      stateQ <= stateD;
      cntQ   <= cntD;
    end
  end

  // cntQ counts consecutive qualifying samples, including the one that entered the state.
  always_comb begin
    stateD   = stateQ;
    cntD     = cntQ;
    strobe_o = 1'b0;
    if (!enable_i) begin
      stateD = IDLE;
      cntD   = '0;
    end else begin
      unique case (stateQ)
        IDLE: begin
          if (btnSync) begin
            stateD = ARMING;
            cntD   = CNT_W'(1);
          end
        end
        ARMING: begin
          if (!btnSync) begin
            stateD = IDLE;
            cntD   = '0;
          end else if (cntQ >= CNT_LAST) begin
            stateD   = HELD;
            cntD     = '0;
            strobe_o = 1'b1;
          end else begin
            cntD = cntInc;
          end
        end
        HELD: begin
          if (!btnSync) begin
            stateD = RELEASING;
            cntD   = CNT_W'(1);
          end
        end
        RELEASING: begin
          if (btnSync) begin
            stateD = HELD;
            cntD   = '0;
          end else if (cntQ >= CNT_LAST) begin
            stateD = IDLE;
            cntD   = '0;
          end else begin
            cntD = cntInc;
          end
        end
        default: begin
          stateD = IDLE;
          cntD   = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/blink_rate_ctrl.sv
// Up/down pushbutton rate selector producing a registered half-period terminal count for the LED blinker.
module blink_rate_ctrl
  import blink_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES  = 2000000,
  parameter int BASE_HALF_PERIOD = 50000000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              locked,
  input  logic              btn_up,
  input  logic              btn_down,
  output logic [RATE_W-1:0] rate_idx,
  output logic [HP_W-1:0]   half_period,
  output logic              rate_changed
);

  logic              upStrobe, downStrobe;
  logic [RATE_W-1:0] rateQ, rateD;
  logic [HP_W-1:0]   halfPeriodQ;
  logic              changedQ, changedD;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) upDebouncer (
    .clock    (clock),
    .reset    (reset),
    .enable_i (locked),
    .btn_i    (btn_up),
    .strobe_o (upStrobe)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) downDebouncer (
    .clock    (clock),
    .reset    (reset),
    .enable_i (locked),
    .btn_i    (btn_down),
    .strobe_o (downStrobe)
  );

  // Simultaneous strobes cancel; requests past either end are ignored without a pulse.
  always_comb begin
    rateD    = rateQ;
    changedD = 1'b0;
    if (locked) begin
      if (upStrobe && !downStrobe && rateQ != MAX_RATE) begin
        rateD    = rateQ + RATE_W'(1);
        changedD = 1'b1;
      end else if (downStrobe && !upStrobe && rateQ != '0) begin
        rateD    = rateQ - RATE_W'(1);
        changedD = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rateQ       <= '0;
      halfPeriodQ <= calcHalfPeriod(BASE_HALF_PERIOD, '0);
      changedQ    <= 1'b0;
    end else begin
      rateQ       <= rateD;
      halfPeriodQ <= calcHalfPeriod(BASE_HALF_PERIOD, rateD);
      changedQ    <= changedD;
    end
  end

  assign rate_idx     = rateQ;
  assign half_period  = halfPeriodQ;
  assign rate_changed = changedQ;

endmodule

// File: tb/tb_blink_rate_ctrl.sv
// Scoreboard bench: expected (rate, half-period) pairs are queued per press and popped on each rate_changed pulse.
module tb_blink_rate_ctrl;

  localparam int DC   = 4;
  localparam int BASE = 256;

  typedef struct {
    logic [2:0]  idx;
    logic [26:0] hp;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        locked = 1'b1;
  logic        btnUp = 1'b0;
  logic        btnDown = 1'b0;
  logic [2:0]  rateIdx;
  logic [26:0] halfPeriod;
  logic        rateChanged;

  exp_t        sb[$];
  int          testsRun = 0;
  int          testsFailed = 0;
  int          pulseCount = 0;
  int          modelIdx = 0;
  bit          monitorOn = 1'b0;

  blink_rate_ctrl #(.DEBOUNCE_CYCLES(DC), .BASE_HALF_PERIOD(BASE)) dut (
    .clock        (clock),
    .reset        (reset),
    .locked       (locked),
    .btn_up       (btnUp),
    .btn_down     (btnDown),
    .rate_idx     (rateIdx),
    .half_period  (halfPeriod),
    .rate_changed (rateChanged)
  );

  always #5 clock = ~clock;

  function automatic logic [26:0] expHp(input int idx);
    int v;
    v = (BASE >> idx) - 1;
    return v[26:0];
  endfunction

  // Every pulse must match the oldest queued expectation.
  always @(negedge clock) begin
    if (monitorOn && rateChanged === 1'b1) begin
      exp_t e;
      pulseCount++;
      testsRun++;
      if (sb.size() == 0) begin
        testsFailed++;
        $display("[TB] FAIL unexpected_pulse: got rate_idx=%0d half_period=%0d, required no pulse", rateIdx, halfPeriod);
      end else begin
        e = sb.pop_front();
        if (rateIdx !== e.idx || halfPeriod !== e.hp) begin
          testsFailed++;
          $display("[TB] FAIL pulse_value: got idx=%0d hp=%0d, required idx=%0d hp=%0d", rateIdx, halfPeriod, e.idx, e.hp);
        end
      end
    end
  end

  task automatic applyStimulus(input logic up, input logic down, input int holdCycles, input int gapCycles);
    btnUp = up;
    btnDown = down;
    repeat (holdCycles) @(negedge clock);
    btnUp = 1'b0;
    btnDown = 1'b0;
    repeat (gapCycles) @(negedge clock);
  endtask

  task automatic checkState(input string name, input int expIdx, input int expPulses, input int startPulses);
    testsRun++;
    if (rateIdx !== expIdx[2:0] || halfPeriod !== expHp(expIdx)) begin
      testsFailed++;
      $display("[TB] FAIL %s_state: got idx=%0d hp=%0d, required idx=%0d hp=%0d", name, rateIdx, halfPeriod, expIdx, expHp(expIdx));
    end
    testsRun++;
    if (pulseCount - startPulses !== expPulses) begin
      testsFailed++;
      $display("[TB] FAIL %s_pulses: got %0d, required %0d", name, pulseCount - startPulses, expPulses);
    end
  endtask

  task automatic pressUp();
    if (modelIdx < 7) begin
      modelIdx++;
      sb.push_back('{idx: modelIdx[2:0], hp: expHp(modelIdx)});
    end
    applyStimulus(1'b1, 1'b0, 10, 12);
  endtask

  task automatic pressDown();
    if (modelIdx > 0) begin
      modelIdx--;
      sb.push_back('{idx: modelIdx[2:0], hp: expHp(modelIdx)});
    end
    applyStimulus(1'b0, 1'b1, 10, 12);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    testsRun++;
    if (rateIdx !== 3'd0 || halfPeriod !== 27'd255 || rateChanged !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_values: got idx=%0d hp=%0d chg=%0b, required 0 255 0", rateIdx, halfPeriod, rateChanged);
    end
    reset = 1'b0;
    monitorOn = 1'b1;
    modelIdx = 0;
    @(negedge clock);
    checkState("after_reset", 0, 0, pulseCount);
  endtask

  task automatic test_down_at_zero();
    int p0 = pulseCount;
    pressDown();
    checkState("down_at_zero", 0, 0, p0);
  endtask

  task automatic test_single_press();
    int p0 = pulseCount;
    pressUp();
    checkState("single_press", 1, 1, p0);
  endtask

  task automatic test_bounce();
    int p0 = pulseCount;
    for (int i = 0; i < 10; i++) begin
      btnUp = ~btnUp;
      repeat (2) @(negedge clock);
    end
    btnUp = 1'b0;
    repeat (12) @(negedge clock);
    checkState("bounce", modelIdx, 0, p0);
  endtask

  task automatic test_saturate_up();
    int p0;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    modelIdx = 0;
    @(negedge clock);
    p0 = pulseCount;
    for (int i = 0; i < 8; i++) pressUp();
    checkState("saturate_up", 7, 7, p0);
  endtask

  task automatic test_simultaneous();
    int p0 = pulseCount;
    applyStimulus(1'b1, 1'b1, 10, 12);
    checkState("simultaneous", modelIdx, 0, p0);
  endtask

  task automatic test_locked();
    int p0;
    int cycles;
    for (int i = 0; i < 4; i++) pressDown();
    p0 = pulseCount;
    locked = 1'b0;
    btnDown = 1'b1;
    repeat (10) @(negedge clock);
    checkState("locked_hold", 3, 0, p0);
    modelIdx = 2;
    sb.push_back('{idx: 3'd2, hp: expHp(2)});
    locked = 1'b1;
    cycles = 0;
    while (pulseCount == p0 && cycles < 20) begin
      @(negedge clock);
      cycles++;
    end
    testsRun++;
    if (pulseCount == p0 || cycles < 3 || cycles > 8) begin
      testsFailed++;
      $display("[TB] FAIL locked_release_latency: got %0d cycles (pulses %0d), required 3..8 cycles", cycles, pulseCount - p0);
    end
    repeat (10) @(negedge clock);
    btnDown = 1'b0;
    repeat (12) @(negedge clock);
    checkState("locked_release", 2, 1, p0);
  endtask

  task automatic test_reset_mid_press();
    int p0 = pulseCount;
    btnUp = 1'b1;
    repeat (5) @(negedge clock);
    reset = 1'b1;
    btnUp = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    modelIdx = 0;
    repeat (15) @(negedge clock);
    checkState("reset_mid_press", 0, 0, p0);
  endtask

  initial begin
    test_reset();
    test_down_at_zero();
    test_single_press();
    test_bounce();
    test_saturate_up();
    test_simultaneous();
    test_locked();
    test_reset_mid_press();
    testsRun++;
    if (sb.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
